// File: rtl/sort4_pkg.sv
// Shared constants and types for the 4-element sorter and its frame collector.
package sort4_pkg;
   localparam int GROUP_N = 4;
   localparam int IDX_W   = $clog2(GROUP_N);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;
endpackage

// File: rtl/sort4_frame_collector_if.sv
// Stream-in / frame-out bundle of the sort4 frame collector.
interface sort4_frame_collector_if #(
   parameter int DW   = 3,
   parameter int ERRW = 8
);
   import sort4_pkg::*;

   logic                   in_valid;
   logic                   in_first;
   logic [DW-1:0]          in_data;
   logic                   out_valid;
   logic [GROUP_N*DW-1:0]  out_data;
   logic                   out_sorted;
   logic                   frame_err;
   logic [ERRW-1:0]        err_cnt;

   // master: the element source that also consumes the frames
   modport master (
      output in_valid, in_first, in_data,
      input  out_valid, out_data, out_sorted, frame_err, err_cnt
   );

   // slave: the collector itself
   modport slave (
      input  in_valid, in_first, in_data,
      output out_valid, out_data, out_sorted, frame_err, err_cnt
   );
endinterface

// File: rtl/sort4_order_check.sv
// Combinational check that a packed frame (e0 in the LSBs) is non-decreasing, unsigned.
module sort4_order_check
   import sort4_pkg::*;
#(
   parameter int DW = 3
) (
   input  logic [GROUP_N*DW-1:0] frame,
   output logic                  sorted
);
   logic [GROUP_N-2:0] pair_ok;

   genvar gi;
   generate
      for (gi = 0; gi < GROUP_N - 1; gi++) begin : g_pair
         assign pair_ok[gi] = (frame[gi*DW +: DW] <= frame[(gi+1)*DW +: DW]);
      end
   endgenerate

   assign sorted = &pair_ok;
endmodule

// File: rtl/sort4_frame_collector.sv
// Regroups the sorter's serial stream into 4-element frames, flags sorted frames
// and counts framing errors (saturating).
module sort4_frame_collector
   import sort4_pkg::*;
#(
   parameter int DW   = 3,
   parameter int ERRW = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   sort4_frame_collector_if.slave        bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_N - 1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DW-1:0]          elem_q [GROUP_N-1];
   logic [DW-1:0]          elem_d [GROUP_N-1];
   logic                   out_valid_q, out_valid_d;
   logic [GROUP_N*DW-1:0]  out_data_q, out_data_d;
   logic                   out_sorted_q, out_sorted_d;
   logic                   frame_err_q, frame_err_d;
   logic [ERRW-1:0]        err_cnt_q, err_cnt_d;

   logic                   err_hit;
   logic [GROUP_N*DW-1:0]  frame_cand;
   logic                   cand_sorted;

   // The last element is never stored: the frame is assembled from e0..e2 plus in_data.
   genvar gi;
   generate
      for (gi = 0; gi < GROUP_N - 1; gi++) begin : g_cand
         assign frame_cand[gi*DW +: DW] = elem_q[gi];
      end
   endgenerate
   assign frame_cand[(GROUP_N-1)*DW +: DW] = bus.in_data;

   sort4_order_check #(.DW(DW)) u_order_check (
      .frame  (frame_cand),
      .sorted (cand_sorted)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      elem_d       = elem_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_sorted_d = out_sorted_q;
      err_hit      = 1'b0;

      if (bus.in_valid) begin
         case (state_q)
            IDLE: begin
               if (bus.in_first) begin
                  elem_d[0] = bus.in_data;
                  idx_d     = IDX_W'(1);
                  state_d   = COLLECT;
               end else begin
                  err_hit = 1'b1;
               end
            end
            COLLECT: begin
               if (bus.in_first) begin
                  // Resync: drop the partial frame, keep this element as the new e0.
                  err_hit   = 1'b1;
                  elem_d[0] = bus.in_data;
                  idx_d     = IDX_W'(1);
               end else if (idx_q == LAST_IDX) begin
                  out_valid_d  = 1'b1;
                  out_data_d   = frame_cand;
                  out_sorted_d = cand_sorted;
                  idx_d        = '0;
                  state_d      = IDLE;
               end else begin
                  elem_d[idx_q] = bus.in_data;
                  idx_d         = idx_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end

      frame_err_d = err_hit;
      err_cnt_d   = err_cnt_q;
      if (err_hit && (err_cnt_q != {ERRW{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         elem_q       <= '{default: '0};
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sorted_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         elem_q       <= elem_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sorted_q <= out_sorted_d;
         frame_err_q  <= frame_err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_sorted = out_sorted_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_sort4_frame_collector.sv
// Directed bench for sort4_frame_collector; a second instance with ERRW=2 covers saturation.
module tb_sort4_frame_collector;
   localparam int DW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int pulses   = 0;
   int last_pulse = 0;
   int p1       = 0;

   sort4_frame_collector_if #(.DW(DW), .ERRW(8)) bus ();
   sort4_frame_collector_if #(.DW(DW), .ERRW(2)) sat_bus ();

   assign sat_bus.in_valid = bus.in_valid;
   assign sat_bus.in_first = bus.in_first;
   assign sat_bus.in_data  = bus.in_data;

   sort4_frame_collector #(.DW(DW), .ERRW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   sort4_frame_collector #(.DW(DW), .ERRW(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sat_bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one input cycle; returns #1 after the sampling edge so registered outputs are visible.
   task automatic cycle(input logic v, input logic f, input logic [DW-1:0] d);
      bus.in_valid = v;
      bus.in_first = f;
      bus.in_data  = d;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.out_valid) begin
         pulses++;
         last_pulse = cyc;
      end
      $display("cyc %0d rst=%0b v=%0b f=%0b d=%0d -> ov=%0b od=0x%03h os=%0b fe=%0b ec=%0d",
               cyc, rst, v, f, d, bus.out_valid, bus.out_data, bus.out_sorted,
               bus.frame_err, bus.err_cnt);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, 1'b0, '0);
      rst = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_data  = '0;

      // Reset state
      rst = 1'b1;
      cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 3'd5);
      rst = 1'b0;
      check("rst_out_valid",  32'(bus.out_valid), 32'd0);
      check("rst_out_data",   32'(bus.out_data), 32'd0);
      check("rst_out_sorted", 32'(bus.out_sorted), 32'd0);
      check("rst_frame_err",  32'(bus.frame_err), 32'd0);
      check("rst_err_cnt",    32'(bus.err_cnt), 32'd0);

      // Clean frame 1,3,5,7
      cycle(1'b1, 1'b1, 3'd1);
      check("clean_ov_e0", 32'(bus.out_valid), 32'd0);
      cycle(1'b1, 1'b0, 3'd3);
      cycle(1'b1, 1'b0, 3'd5);
      check("clean_ov_e2", 32'(bus.out_valid), 32'd0);
      cycle(1'b1, 1'b0, 3'd7);
      check("clean_ov",     32'(bus.out_valid), 32'd1);
      check("clean_data",   32'(bus.out_data), 32'hF59);
      check("clean_sorted", 32'(bus.out_sorted), 32'd1);
      check("clean_errcnt", 32'(bus.err_cnt), 32'd0);
      cycle(1'b0, 1'b0, '0);
      check("clean_ov_drop",  32'(bus.out_valid), 32'd0);
      check("clean_data_hold", 32'(bus.out_data), 32'hF59);

      // Unsorted 4,2,6,6
      cycle(1'b1, 1'b1, 3'd4);
      cycle(1'b1, 1'b0, 3'd2);
      cycle(1'b1, 1'b0, 3'd6);
      cycle(1'b1, 1'b0, 3'd6);
      check("unsorted_ov",     32'(bus.out_valid), 32'd1);
      check("unsorted_data",   32'(bus.out_data), 32'hD94);
      check("unsorted_sorted", 32'(bus.out_sorted), 32'd0);

      // All equal 2,2,2,2
      cycle(1'b1, 1'b1, 3'd2);
      cycle(1'b1, 1'b0, 3'd2);
      cycle(1'b1, 1'b0, 3'd2);
      cycle(1'b1, 1'b0, 3'd2);
      check("equal_ov",     32'(bus.out_valid), 32'd1);
      check("equal_data",   32'(bus.out_data), 32'h492);
      check("equal_sorted", 32'(bus.out_sorted), 32'd1);
      cycle(1'b0, 1'b0, '0);

      // Gapped frame 1,2,3,4 then back-to-back frame 0,1,2,3
      pulses = 0;
      cycle(1'b1, 1'b1, 3'd1);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 3'd2);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 3'd3);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 3'd4);
      check("gap_pulses", 32'(pulses), 32'd1);
      check("gap_data",   32'(bus.out_data), 32'h8D1);
      p1 = last_pulse;
      cycle(1'b1, 1'b1, 3'd0);
      cycle(1'b1, 1'b0, 3'd1);
      cycle(1'b1, 1'b0, 3'd2);
      check("b2b_no_early", 32'(pulses), 32'd1);
      cycle(1'b1, 1'b0, 3'd3);
      check("b2b_pulses",  32'(pulses), 32'd2);
      check("b2b_spacing", 32'(last_pulse - p1), 32'd4);
      check("b2b_data",    32'(bus.out_data), 32'h688);

      // Resync: 5,6 then in_first with 0,1,2,3
      do_reset();
      cycle(1'b1, 1'b1, 3'd5);
      cycle(1'b1, 1'b0, 3'd6);
      check("resync_no_err", 32'(bus.frame_err), 32'd0);
      cycle(1'b1, 1'b1, 3'd0);
      check("resync_ferr",  32'(bus.frame_err), 32'd1);
      check("resync_cnt",   32'(bus.err_cnt), 32'd1);
      check("resync_no_ov", 32'(bus.out_valid), 32'd0);
      cycle(1'b1, 1'b0, 3'd1);
      check("resync_ferr_drop", 32'(bus.frame_err), 32'd0);
      cycle(1'b1, 1'b0, 3'd2);
      cycle(1'b1, 1'b0, 3'd3);
      check("resync_ov",   32'(bus.out_valid), 32'd1);
      check("resync_data", 32'(bus.out_data), 32'h688);
      check("resync_fe_ov_excl", 32'(bus.frame_err), 32'd0);

      // Two stray elements while IDLE
      do_reset();
      cycle(1'b1, 1'b0, 3'd2);
      check("idle_err1_fe",  32'(bus.frame_err), 32'd1);
      cycle(1'b1, 1'b0, 3'd3);
      check("idle_err2_cnt", 32'(bus.err_cnt), 32'd2);
      check("idle_err_no_ov", 32'(bus.out_valid), 32'd0);

      // Saturation on the ERRW=2 instance
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 3'(i));
         check($sformatf("sat_cnt_%0d", i), 32'(sat_bus.err_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      check("sat_wide_cnt", 32'(bus.err_cnt), 32'd5);

      // Reset mid-frame
      do_reset();
      cycle(1'b1, 1'b1, 3'd7);
      cycle(1'b1, 1'b0, 3'd7);
      cycle(1'b1, 1'b0, 3'd7);
      cycle(1'b1, 1'b0, 3'd7);
      check("pre_rst_data", 32'(bus.out_data), 32'hFFF);
      cycle(1'b1, 1'b1, 3'd1);
      cycle(1'b1, 1'b0, 3'd2);
      rst = 1'b1;
      cycle(1'b0, 1'b0, '0);
      rst = 1'b0;
      check("midrst_ov",   32'(bus.out_valid), 32'd0);
      check("midrst_data", 32'(bus.out_data), 32'd0);
      check("midrst_sorted", 32'(bus.out_sorted), 32'd0);
      check("midrst_fe",   32'(bus.frame_err), 32'd0);
      cycle(1'b1, 1'b1, 3'd3);
      check("after_rst_fe", 32'(bus.frame_err), 32'd0);
      cycle(1'b1, 1'b0, 3'd4);
      cycle(1'b1, 1'b0, 3'd5);
      check("after_rst_no_ov", 32'(bus.out_valid), 32'd0);
      cycle(1'b1, 1'b0, 3'd6);
      check("after_rst_ov",     32'(bus.out_valid), 32'd1);
      check("after_rst_data",   32'(bus.out_data), 32'hD63);
      check("after_rst_sorted", 32'(bus.out_sorted), 32'd1);
      check("after_rst_cnt",    32'(bus.err_cnt), 32'd0);
      cycle(1'b0, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
